// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: the ALU result has priority, long-op returns go through a FIFO,
// and a pending-destination scoreboard drives the hazard output. Define WB_BYPASS_EN to let long ops skip an empty FIFO.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_wa,
  input  logic [DW-1:0]              alu_wd,
  input  logic                       lng_valid,
  output logic                       lng_ready,
  input  logic [AW-1:0]              lng_wa,
  input  logic [DW-1:0]              lng_wd,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_wa,
  input  logic [AW-1:0]              chk_ra0,
  input  logic [AW-1:0]              chk_ra1,
  input  logic [AW-1:0]              chk_wa,
  output logic                       hazard,
  output logic [$clog2(DEPTH):0]     pend_cnt,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_wa,
  output logic [DW-1:0]              rf_wd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NR-1:0] pend_q, pend_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wa_q, rf_wa_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;

  ent_t head;
  logic empty, push, pop, byp;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    empty     = (cnt_q == '0);
    lng_ready = (cnt_q != CW'(DEPTH));
    pop       = !alu_valid && !empty;
`ifdef WB_BYPASS_EN
    byp       = empty && !alu_valid && lng_valid;
`else
    byp       = 1'b0;
`endif
    // A bypassed entry is consumed by the output register, so it never occupies a FIFO slot.
    push      = lng_valid && lng_ready && !byp;

    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    pend_d  = pend_q;
    if (alu_valid) begin
      rf_we_d = (alu_wa != '0);
      rf_wa_d = alu_wa;
      rf_wd_d = alu_wd;
    end else if (pop) begin
      rf_we_d = (head.wa != '0);
      rf_wa_d = head.wa;
      rf_wd_d = head.wd;
      pend_d[head.wa] = 1'b0;
    end else if (byp) begin
      rf_we_d = (lng_wa != '0);
      rf_wa_d = lng_wa;
      rf_wd_d = lng_wd;
      pend_d[lng_wa] = 1'b0;
    end
    // Set after clear so a same-edge reissue keeps the register pending.
    if (issue_valid) pend_d[issue_wa] = 1'b1;
    pend_d[0] = 1'b0;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{wa: lng_wa, wd: lng_wd};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign hazard   = pend_q[chk_ra0] | pend_q[chk_ra1] | pend_q[chk_wa];
  assign pend_cnt = cnt_q;
  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: a queue/array reference model predicts every register write
// and the edge it lands on. A separate monitor compares each observed write against that prediction.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2 ** AW;

  logic          clk, rst;
  logic          alu_valid, lng_valid, lng_ready, issue_valid, hazard;
  logic [AW-1:0] alu_wa, lng_wa, issue_wa, chk_ra0, chk_ra1, chk_wa, rf_wa;
  logic [DW-1:0] alu_wd, lng_wd, rf_wd;
  logic [$clog2(DEPTH):0] pend_cnt;
  logic          rf_we;

  regfile_wb_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_wa(lng_wa), .lng_wd(lng_wd),
    .issue_valid(issue_valid), .issue_wa(issue_wa),
    .chk_ra0(chk_ra0), .chk_ra1(chk_ra1), .chk_wa(chk_wa),
    .hazard(hazard), .pend_cnt(pend_cnt),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    int            edge_no;
  } wr_t;

  wr_t expq[$];
  wr_t fq[$];
  bit  pend[NR];
  int  edge_n = 0;
  int  checks = 0;
  int  passed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Monitor: every observed write must match the oldest predicted write, including its edge.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (rf_we === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          $display("FAIL unexpected_write got wa=%0d wd=%0h at edge %0d exp none", rf_wa, rf_wd, edge_n);
        end else begin
          e = expq.pop_front();
          if (rf_wa === e.wa && rf_wd === e.wd && edge_n == e.edge_no) passed++;
          else $display("FAIL write got wa=%0d wd=%0h edge=%0d exp wa=%0d wd=%0h edge=%0d",
                        rf_wa, rf_wd, edge_n, e.wa, e.wd, e.edge_no);
        end
      end
    end
  end

  function automatic void predict(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input int en);
    wr_t w;
    if (wa != 0) begin
      w.wa = wa; w.wd = wd; w.edge_no = en;
      expq.push_back(w);
    end
  endfunction

  // One clock: drive inputs, check combinational outputs against the model, then advance the model.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input bit iv, input logic [AW-1:0] ia,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] cw);
    bit  ready, acc;
    int  en;
    wr_t h;
    @(negedge clk);
    alu_valid = av; alu_wa = aa; alu_wd = ad;
    lng_valid = lv; lng_wa = la; lng_wd = ld;
    issue_valid = iv; issue_wa = ia;
    chk_ra0 = r0; chk_ra1 = r1; chk_wa = cw;
    #1;
    ready = (fq.size() != DEPTH);
    chk("lng_ready", lng_ready, ready);
    chk("pend_cnt", pend_cnt, fq.size());
    chk("hazard", hazard, pend[r0] | pend[r1] | pend[cw]);
    en  = edge_n + 1;
    acc = lv && ready;
    if (av) begin
      predict(aa, ad, en);
    end else if (fq.size() > 0) begin
      h = fq.pop_front();
      predict(h.wa, h.wd, en);
      pend[h.wa] = 0;
    end
`ifdef WB_BYPASS_EN
    else if (lv) begin
      predict(la, ld, en);
      pend[la] = 0;
      acc = 0;
    end
`endif
    if (acc) begin
      h.wa = la; h.wd = ld; h.edge_no = 0;
      fq.push_back(h);
    end
    if (iv && ia != 0) pend[ia] = 1;
  endtask

  task automatic idle(input logic [AW-1:0] c);
    step(0, 0, 0, 0, 0, 0, 0, 0, c, c, c);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_wa = '0; alu_wd = '0;
    lng_valid = 0; lng_wa = '0; lng_wd = '0;
    issue_valid = 0; issue_wa = '0;
    chk_ra0 = '0; chk_ra1 = '0; chk_wa = '0;
    repeat (2) @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wa", rf_wa, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_lng_ready", lng_ready, 1);
    rst = 1'b0;

    // ALU writes, including the r0 destination that must not write
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h9, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    // ALU priority delays a queued long op
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    step(0, 0, 0, 1, 7, 32'hAA, 0, 0, 7, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 32'h300 + i, 0, 0, 0, 0, 0, 7, 7, 7);
    idle(7);
    idle(7);

    // Fill while ALU holds the port, offer a fifth, then drain with pointer wrap
    for (int i = 1; i <= 4; i++) step(1, 10 + i, i, 1, i, 32'hB0 + i, 0, 0, 0, 0, 0);
    step(1, 15, 5, 1, 5, 32'hB5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 20 + i, 32'hC0 + i, 0, 0, 0, 0, 0);
    repeat (6) idle(0);

    // Scoreboard set, same-edge clear/set, and issue to r0
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
    step(1, 2, 32'h22, 1, 9, 32'h99, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9);
    idle(9);
    step(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 9, 9);
    idle(9);
    idle(9);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0);

    // Long op into an empty FIFO
    step(0, 0, 0, 1, 12, 32'h55, 1, 12, 0, 0, 0);
    idle(12);
    idle(12);

    // Reset with entries queued
    for (int i = 0; i < 3; i++) step(1, 4, i, 1, 16 + i, 32'hD0 + i, 1, 16 + i, 0, 0, 0);
    @(negedge clk);
    alu_valid = 0; lng_valid = 0; issue_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_pend_cnt", pend_cnt, 0);
    chk("mid_rst_lng_ready", lng_ready, 1);
    for (int a = 0; a < NR; a++) begin
      chk_ra0 = a; chk_ra1 = a; chk_wa = a;
      #1 chk("mid_rst_hazard", hazard, 0);
    end
    fq.delete();
    for (int a = 0; a < NR; a++) pend[a] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) idle(17);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] aa, la, ia, r0, r1, cw;
      aa = AW'($urandom_range(0, NR - 1));
      la = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NR - 1));
      ia = AW'($urandom_range(0, NR - 1));
      r0 = AW'($urandom_range(0, NR - 1));
      r1 = AW'($urandom_range(0, NR - 1));
      cw = AW'($urandom_range(0, NR - 1));
      step($urandom_range(0, 1), aa, $urandom, ($urandom_range(0, 9) < 6), la, $urandom,
           ($urandom_range(0, 9) < 3), ia, r0, r1, cw);
    end

    repeat (DEPTH + 4) idle(0);
    @(negedge clk);
    chk("expq_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writer-side controller for the CPU register file's single write port (rf_we/rf_wa/rf_wd).
- Merges two result sources into that port:
  - the fixed-latency ALU/EX result, which cannot stall;
  - a variable-latency long-op return stream (load/divide), via a valid/ready handshake and a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against in-flight long ops.

Parameters:
- DEPTH, 4, long-op FIFO entries (power of 2, >=2)
- DW, 32, data width
- AW, 5, register address width (2**AW registers)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_wa  in  AW  ALU destination
- alu_wd  in  DW  ALU data
- lng_valid  in  1  long-op result offered
- lng_ready  out  1  long-op result accepted when lng_valid&&lng_ready at clk edge
- lng_wa  in  AW  long-op destination
- lng_wd  in  DW  long-op data
- issue_valid  in  1  long op issued this cycle
- issue_wa  in  AW  its destination
- chk_ra0  in  AW  decode source 0
- chk_ra1  in  AW  decode source 1
- chk_wa  in  AW  decode destination
- hazard  out  1  combinational: any checked register pending
- pend_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  AW  register-file write address (registered)
- rf_wd  out  DW  register-file write data (registered)

Behaviour:
- Reset, async and active-high: rf_we=0, rf_wa=0, rf_wd=0, FIFO empty, pend_cnt=0, lng_ready=1, all pending bits 0. Reset mid-operation discards queued entries and pending state.
- Output register: each edge loads exactly one source, in this priority:
  - ALU wins: if alu_valid, rf_we<=(alu_wa!=0), rf_wa<=alu_wa, rf_wd<=alu_wd.
  - Otherwise, if the FIFO is non-empty, pop the head: rf_we<=(head.wa!=0), rf_wa/rf_wd<=head.
  - Otherwise rf_we<=0, with rf_wa/rf_wd held.
- Latency:
  - ALU: 1 edge; sampled at edge N, rf_we is high in the cycle after N.
  - Long op: accepted at edge N, earliest rf_we is in the cycle after N+1. Each cycle with alu_valid=1 delays it by one more.
- FIFO:
  - lng_ready = (count != DEPTH). It depends only on registered count, not on same-cycle pop.
  - Push and pop in the same edge are legal; count is unchanged.
  - Pointers wrap modulo DEPTH. Order is strictly FIFO.
  - When full, lng_ready=0 and lng_valid is ignored.
  - Entries with wa==0 are queued and popped normally but produce rf_we=0.
- Scoreboard (2**AW bits):
  - Set: issue_valid && issue_wa!=0 sets pend[issue_wa].
  - Clear: a pop with head.wa!=0 clears pend[head.wa].
  - Same register set and cleared on the same edge: set wins.
  - Bit 0 is always 0.
  - Decode guarantees no issue to an already-pending wa; hazard covers this, since WAW is checked through chk_wa.
- hazard = pend[chk_ra0] | pend[chk_ra1] | pend[chk_wa]. It reflects registered state only. The register file's own write bypass covers the write-back cycle itself.
- ALU writes to a pending register do not alter pend; decode prevents this case via hazard.

Optional Feature:
- WB_BYPASS_EN defined:
  - If FIFO empty, alu_valid=0 and lng_valid=1 at edge N, the entry goes straight to the output register and is not written to the FIFO.
  - Long-op latency is then 1 edge; pend is cleared on edge N.
  - lng_ready is unchanged.
- Undefined: all long-op results pass through the FIFO (2-edge minimum).

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued -> immediately rf_we=0, pend_cnt=0, lng_ready=1, hazard=0 for all addresses; after release, no stale writes appear.
- ALU only: alu_valid=1, wa=5, wd=0x1234 at edge N -> cycle after N shows rf_we=1, rf_wa=5, rf_wd=0x1234. With alu_wa=0 -> rf_we=0.
- Priority/starvation:
  - Stimulus: push long-op wa=7/0xAA, then hold alu_valid=1 for 3 cycles (wa=3).
  - Required: rf_wa=3 three times, then rf_wa=7 with 0xAA.
  - Without WB_BYPASS_EN: pend[7] stays 1 until the pop edge.
- Full/wrap:
  - Stimulus: hold alu_valid=1 and push 4 entries wa=1..4.
  - Required: lng_ready=0 with pend_cnt=4.
  - Then a 5th offer with lng_valid=1 is not taken.
  - Releasing alu_valid drains 1,2,3,4 in order.
  - Push during drain wraps the pointers; order is preserved.
- Scoreboard:
  - issue_valid wa=9 -> hazard=1 for chk_ra0=9, chk_ra1=9 or chk_wa=9.
  - Pop of wa=9 clears it; with an issue of wa=9 on the same edge, the bit stays 1.
  - issue_wa=0 never raises hazard.
- WB_BYPASS_EN: empty FIFO, lng_valid=1 wa=12/0x55 at edge N -> rf_we=1, rf_wa=12 in the cycle after N, pend_cnt stays 0. With the macro undefined, the same stimulus gives rf_we in the cycle after N+1.
